maxpooling1: RTL and testbench

MAXPOOLING1 -- requirements
Module: maxpooling1

---
 rtl/maxpooling1_pkg.sv | 14 +
 rtl/maxpooling1_max_of_four.sv | 23 ++
 rtl/maxpooling1.sv | 121 ++++++++++++
 tb/tb_maxpooling1.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/maxpooling1_pkg.sv
// Shared constants and FSM encoding for the two-channel 2x2/stride-2 max-pooling block.
package maxpooling1_pkg;
  localparam int BITWIDTH_DEFAULT = 32;
  localparam int IN_DIM           = 28;
  localparam int OUT_DIM          = 14;
  localparam int CHANNELS         = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    POOL    = 2'd2,
    DONE    = 2'd3
  } state_t;
endpackage

// File: rtl/maxpooling1_max_of_four.sv
// Combinational signed maximum of four two's-complement operands.
module max_of_four
  import maxpooling1_pkg::*;
#(
  parameter int bitwidth = BITWIDTH_DEFAULT
) (
  input  logic signed [bitwidth-1:0] in0,
  input  logic signed [bitwidth-1:0] in1,
  input  logic signed [bitwidth-1:0] in2,
  input  logic signed [bitwidth-1:0] in3,
  output logic signed [bitwidth-1:0] max_out
);

  function automatic logic signed [bitwidth-1:0] smax(
    input logic signed [bitwidth-1:0] a,
    input logic signed [bitwidth-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  assign max_out = smax(smax(in0, in1), smax(in2, in3));

endmodule

// File: rtl/maxpooling1.sv
// Captures a 2x28x28 feature map, pools it one output row per cycle into a registered
// 2x14x14 map, and holds the result under an enable/reply handshake on both sides.
module maxpooling1
  import maxpooling1_pkg::*;
#(
  parameter int bitwidth = BITWIDTH_DEFAULT
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [CHANNELS*IN_DIM*IN_DIM*bitwidth-1:0]    featuremap1,
  input  logic                                          enable,
  output logic                                          reply_to_previous_device,
  input  logic                                          reply_from_next_device,
  output logic [CHANNELS*OUT_DIM*OUT_DIM*bitwidth-1:0]  featuremap2,
  output logic                                          finished_for_next_device
);

  state_t      state_q;
  logic [3:0]  row_q;
  logic [4:0]  row_even;
  logic [4:0]  row_odd;

  logic signed [bitwidth-1:0] buf_q    [CHANNELS][IN_DIM][IN_DIM];
  logic signed [bitwidth-1:0] fm2_q    [CHANNELS][OUT_DIM][OUT_DIM];
  logic signed [bitwidth-1:0] pool_row [CHANNELS][OUT_DIM];

  assign row_even = {row_q, 1'b0};
  assign row_odd  = {row_q, 1'b1};

  // Control: handshake flags are registered alongside the state they mirror.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q                  <= IDLE;
      row_q                    <= '0;
      reply_to_previous_device <= 1'b0;
      finished_for_next_device <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q                  <= CAPTURE;
            reply_to_previous_device <= 1'b1;
          end
        end
        CAPTURE: begin
          state_q                  <= POOL;
          row_q                    <= '0;
          reply_to_previous_device <= 1'b0;
        end
        POOL: begin
          row_q <= row_q + 4'd1;
          if (row_q == 4'(OUT_DIM - 1)) begin
            state_q                  <= DONE;
            finished_for_next_device <= 1'b1;
          end
        end
        DONE: begin
          if (reply_from_next_device) begin
            state_q                  <= IDLE;
            finished_for_next_device <= 1'b0;
          end
        end
        default: begin
          state_q                  <= IDLE;
          reply_to_previous_device <= 1'b0;
          finished_for_next_device <= 1'b0;
        end
      endcase
    end
  end

  // Input snapshot: upstream may change featuremap1 freely once CAPTURE closes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int i = 0; i < IN_DIM; i++)
          for (int j = 0; j < IN_DIM; j++)
            buf_q[c][i][j] <= '0;
    end else if (state_q == CAPTURE) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int i = 0; i < IN_DIM; i++)
          for (int j = 0; j < IN_DIM; j++)
            buf_q[c][i][j] <= featuremap1[(c*IN_DIM*IN_DIM + j*IN_DIM + i)*bitwidth +: bitwidth];
    end
  end

  // Pooling datapath: one max unit per output column per channel, all fed from the active row pair.
  for (genvar gc = 0; gc < CHANNELS; gc++) begin : g_ch
    for (genvar gj = 0; gj < OUT_DIM; gj++) begin : g_col
      max_of_four #(.bitwidth(bitwidth)) u_max (
        .in0    (buf_q[gc][row_even][2*gj]),
        .in1    (buf_q[gc][row_odd][2*gj]),
        .in2    (buf_q[gc][row_even][2*gj+1]),
        .in3    (buf_q[gc][row_odd][2*gj+1]),
        .max_out(pool_row[gc][gj])
      );
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int i = 0; i < OUT_DIM; i++)
          for (int j = 0; j < OUT_DIM; j++)
            fm2_q[c][i][j] <= '0;
    end else if (state_q == POOL) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int j = 0; j < OUT_DIM; j++)
          fm2_q[c][row_q][j] <= pool_row[c][j];
    end
  end

  for (genvar gc = 0; gc < CHANNELS; gc++) begin : g_out_ch
    for (genvar gi = 0; gi < OUT_DIM; gi++) begin : g_out_row
      for (genvar gj = 0; gj < OUT_DIM; gj++) begin : g_out_col
        assign featuremap2[(gc*OUT_DIM*OUT_DIM + gj*OUT_DIM + gi)*bitwidth +: bitwidth] = fm2_q[gc][gi][gj];
      end
    end
  end

endmodule

// File: tb/tb_maxpooling1.sv
// Self-checking bench for maxpooling1: table-driven windows, ramp, random maps and handshake corners.
module tb_maxpooling1;
  localparam int BW    = 32;
  localparam int FM1_W = 2*28*28*BW;
  localparam int FM2_W = 2*14*14*BW;
  localparam int IMIN  = 32'sh8000_0000;
  localparam int IMAX  = 32'sh7fff_ffff;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic             reply_from_next_device = 1'b0;
  logic [FM1_W-1:0] featuremap1 = '0;
  logic [FM2_W-1:0] featuremap2;
  logic             reply_to_previous_device;
  logic             finished_for_next_device;

  int n_cmp = 0;
  int n_bad = 0;
  int in_mem  [2][28][28];
  int exp_mem [2][14][14];

  typedef struct {
    int c, i, j;
    int w0, w1, w2, w3;
    int expv;
  } vec_t;
  vec_t vecs [6];

  maxpooling1 #(.bitwidth(BW)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .featuremap1              (featuremap1),
    .enable                   (enable),
    .reply_to_previous_device (reply_to_previous_device),
    .reply_from_next_device   (reply_from_next_device),
    .featuremap2              (featuremap2),
    .finished_for_next_device (finished_for_next_device)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic int get_out(input int c, input int i, input int j);
    return featuremap2[(196*c + 14*j + i)*BW +: BW];
  endfunction

  task automatic pack_input();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 28; i++)
        for (int j = 0; j < 28; j++)
          featuremap1[(784*c + 28*j + i)*BW +: BW] = in_mem[c][i][j];
  endtask

  task automatic fill_random();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 28; i++)
        for (int j = 0; j < 28; j++)
          in_mem[c][i][j] = int'($urandom());
  endtask

  // Reference: plain 2x2 window maximum over the stored input picture.
  task automatic model();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 14; i++)
        for (int j = 0; j < 14; j++) begin
          int m;
          m = in_mem[c][2*i][2*j];
          if (in_mem[c][2*i+1][2*j]   > m) m = in_mem[c][2*i+1][2*j];
          if (in_mem[c][2*i][2*j+1]   > m) m = in_mem[c][2*i][2*j+1];
          if (in_mem[c][2*i+1][2*j+1] > m) m = in_mem[c][2*i+1][2*j+1];
          exp_mem[c][i][j] = m;
        end
  endtask

  task automatic check_map(input string name);
    int bad, fa, fr;
    bad = 0; fa = 0; fr = 0;
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 14; i++)
        for (int j = 0; j < 14; j++)
          if (get_out(c, i, j) != exp_mem[c][i][j]) begin
            if (bad == 0) begin fa = get_out(c, i, j); fr = exp_mem[c][i][j]; end
            bad++;
          end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL %s: %0d elements differ, first got %0d, required %0d", name, bad, fa, fr);
    end
  endtask

  task automatic wait_finish(inout int cycles);
    while (!finished_for_next_device && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  // One full operation; latency counts the enable-sampling edge as edge 1.
  task automatic run_op(input string name, input bit zero_after, input int hold);
    int cycles;
    logic [FM2_W-1:0] snap;
    bit stable;
    pack_input();
    model();
    @(negedge clk) enable = 1'b1;
    @(negedge clk) enable = 1'b0;
    cycles = 1;
    check({name, "_ack_high"}, int'(reply_to_previous_device), 1);
    @(negedge clk);
    cycles++;
    check({name, "_ack_one_cycle"}, int'(reply_to_previous_device), 0);
    if (zero_after) featuremap1 = '0;
    wait_finish(cycles);
    check({name, "_latency"}, cycles, 16);
    check_map({name, "_map"});
    if (hold > 0) begin
      snap = featuremap2;
      stable = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if (!finished_for_next_device || featuremap2 != snap) stable = 1'b0;
      end
      check({name, "_done_hold"}, int'(stable), 1);
    end
    reply_from_next_device = 1'b1;
    @(negedge clk) reply_from_next_device = 1'b0;
    check({name, "_idle_after_reply"}, int'({finished_for_next_device, reply_to_previous_device}), 0);
  endtask

  initial begin
    int cycles;
    bit seen;

    vecs[0] = '{0, 0, 0,   -5,   -1,   -7, IMIN,   -1};
    vecs[1] = '{1, 13, 13,  7,    7,    7,    7,    7};
    vecs[2] = '{0, 6, 9,  IMIN, IMIN, IMIN, IMIN, IMIN};
    vecs[3] = '{1, 3, 0,    0,   -1,    1,   -2,    1};
    vecs[4] = '{0, 13, 0, IMIN, IMAX,   -1,    0, IMAX};
    vecs[5] = '{1, 0, 13, -100, -100, -200, -300, -100};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_fm2", int'(featuremap2 == '0), 1);
    check("rst_flags", int'({reply_to_previous_device, finished_for_next_device}), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_enable", int'({reply_to_previous_device, finished_for_next_device}), 0);

    // Ramp with a long DONE hold
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 28; i++)
        for (int j = 0; j < 28; j++)
          in_mem[c][i][j] = 784*c + 28*j + i;
    run_op("ramp", 1'b0, 50);
    check("ramp_out000", get_out(0, 0, 0), 29);
    check("ramp_out1_13_13", get_out(1, 13, 13), 1567);

    // Table-driven windows on a random background
    for (int k = 0; k < 6; k++) begin
      fill_random();
      in_mem[vecs[k].c][2*vecs[k].i][2*vecs[k].j]     = vecs[k].w0;
      in_mem[vecs[k].c][2*vecs[k].i+1][2*vecs[k].j]   = vecs[k].w1;
      in_mem[vecs[k].c][2*vecs[k].i][2*vecs[k].j+1]   = vecs[k].w2;
      in_mem[vecs[k].c][2*vecs[k].i+1][2*vecs[k].j+1] = vecs[k].w3;
      run_op($sformatf("vec%0d", k), 1'b0, 0);
      check($sformatf("vec%0d_elem", k), get_out(vecs[k].c, vecs[k].i, vecs[k].j), vecs[k].expv);
    end

    // Random maps
    for (int k = 0; k < 3; k++) begin
      fill_random();
      run_op($sformatf("rand%0d", k), 1'b0, 0);
    end

    // Input zeroed right after capture
    fill_random();
    run_op("input_change", 1'b1, 0);

    // Reset at POOL row 7
    fill_random();
    pack_input();
    @(negedge clk) enable = 1'b1;
    @(negedge clk) enable = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_fm2", int'(featuremap2 == '0), 1);
    check("midrst_flags", int'({reply_to_previous_device, finished_for_next_device}), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (finished_for_next_device || reply_to_previous_device) seen = 1'b1;
    end
    check("midrst_no_restart", int'(seen), 0);
    fill_random();
    run_op("after_reset", 1'b0, 0);

    // Back-to-back with enable held high
    fill_random();
    pack_input();
    model();
    @(negedge clk) enable = 1'b1;
    cycles = 0;
    wait_finish(cycles);
    check("b2b_first_done", int'(finished_for_next_device), 1);
    check_map("b2b_first_map");
    reply_from_next_device = 1'b1;
    @(negedge clk) reply_from_next_device = 1'b0;
    check("b2b_idle_gap", int'({finished_for_next_device, reply_to_previous_device}), 0);
    @(negedge clk);
    check("b2b_recapture", int'(reply_to_previous_device), 1);
    enable = 1'b0;
    cycles = 1;
    wait_finish(cycles);
    check("b2b_second_latency", cycles, 16);
    check_map("b2b_second_map");
    reply_from_next_device = 1'b1;
    @(negedge clk) reply_from_next_device = 1'b0;
    check("b2b_final_idle", int'({finished_for_next_device, reply_to_previous_device}), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
